tsg_gray_param: RTL and testbench
=================================

TSG_GRAY_PARAM -- requirements
Module: tsg_gray_param

Interface
REQ-001 SHALL have parameter GF_LEN, default 10: Galois-field element width in bits.
REQ-002 SHALL have parameter TP_NUM, default 3, legal range 1..8: number of least-reliable test positions; 2^TP_NUM test patterns.
REQ-003 SHALL have parameter SYND_NUM, default 3, legal range 1..8: number of odd syndromes S1, S3, ..., S(2*SYND_NUM-1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port in_ctr_Arst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_ctr_start, input, 1, one-cycle pulse that loads operands and begins a pattern sequence.
REQ-007 SHALL have port in_ctr_abort, input, 1, cancels the sequence in progress.
REQ-008 SHALL have port in_hd_synd, input, SYND_NUM*GF_LEN, hard-decision syndromes; slice k is S(2k+1).
REQ-009 SHALL have port in_tp_pow, input, TP_NUM*SYND_NUM*GF_LEN, precomputed powers; slice (j*SYND_NUM+k) is alpha_j^(2k+1).
REQ-010 SHALL have port out_busy, output, 1, high outside IDLE.
REQ-011 SHALL have port out_valid, output, 1, high when the output syndrome set is valid.
REQ-012 SHALL have port in_ready, input, 1, downstream accept; a transfer occurs when out_valid and in_ready are both high.
REQ-013 SHALL have port out_test_synd, output, SYND_NUM*GF_LEN, test-pattern syndromes, same slicing as in_hd_synd.
REQ-014 SHALL have port out_gray, output, TP_NUM, gray code of the current test pattern (bit j set = position j flipped).
REQ-015 SHALL have port out_last, output, 1, high with out_valid on the final pattern.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-017 SHALL, in IDLE on in_ctr_start, register in_hd_synd into the syndrome accumulator and in_tp_pow into an internal power table, clear the gray counter, and enter LOAD.
REQ-018 SHALL, in LOAD, assert out_valid for pattern 0 (out_gray=0, out_test_synd=hard-decision syndromes) and enter RUN on the next cycle; first out_valid is exactly 1 cycle after start.
REQ-019 SHALL hold out_valid, out_test_synd, out_gray and out_last stable while out_valid is high and in_ready is low.
REQ-020 SHALL, on each transfer of pattern n < 2^TP_NUM-1, advance the binary counter, determine the single changed gray bit j, and XOR every accumulator slice k with table slice (j,k), presenting pattern n+1 on the next cycle with out_valid high (one pattern per cycle under continuous in_ready).
REQ-021 SHALL assert out_last only for pattern 2^TP_NUM-1 (out_gray = 1 followed by TP_NUM-1 zeros, MSB first), and return to IDLE on its transfer with out_valid low the next cycle.
REQ-022 SHALL perform all field addition as bitwise XOR; no carries, widths fixed at GF_LEN.
REQ-023 SHALL ignore in_ctr_start when out_busy is high.
REQ-024 SHALL, on in_ctr_abort in any state, enter IDLE next cycle with out_valid and out_last low; abort takes priority over a simultaneous transfer or start.
REQ-025 SHALL ignore input operand changes after the loading cycle; the power table is used only from registered copies.

Reset
REQ-026 SHALL, on in_ctr_Arst_n low, immediately and asynchronously force state IDLE, out_busy=0, out_valid=0, out_last=0, out_gray=0, out_test_synd=0, power table=0.
REQ-027 SHALL accept no start on the rising edge where in_ctr_Arst_n deasserts; reset mid-sequence discards all progress.

Configuration
REQ-028 SHALL support macro TSG_ZERO_DET_EN: when defined, add output out_zero (1 bit), registered with out_test_synd, high when every syndrome slice equals zero (valid codeword candidate), reset 0; when undefined, port and logic are absent and behaviour is otherwise identical.

Verification
REQ-029 SHALL cover: GF_LEN=10, TP_NUM=3, SYND_NUM=3, in_ready tied high, start with hd_synd={0x001,0x002,0x004}, pow j0={0x010,0,0} j1={0x020,0,0} j2={0x040,0,0} -> 8 consecutive valids, out_gray 0,1,3,2,6,7,5,4, S1 0x001,0x011,0x031,0x021,0x061,0x071,0x051,0x041, out_last on 8th only.
REQ-030 SHALL cover: same run with in_ready low 3 cycles on pattern 2 -> out_gray=3 and S1=0x031 held unchanged for 3 cycles, then sequence resumes without skip.
REQ-031 SHALL cover: in_ctr_abort at pattern 4 simultaneous with in_ready -> next cycle out_valid=0, out_busy=0; subsequent start restarts at out_gray=0.
REQ-032 SHALL cover: in_ctr_Arst_n low asynchronously mid-clock at pattern 5 -> all outputs 0 before next rising edge.
REQ-033 SHALL cover: in_ctr_start pulsed during RUN with different hd_synd -> ignored, sequence values unchanged.
REQ-034 SHALL cover, with TSG_ZERO_DET_EN: hd_synd={0x011,0,0}, pow j0={0x011,0,0} -> out_zero=0 on pattern 0, 1 on pattern 1 (out_gray=1).

Source files
------------

// File: rtl/tsg_gray_param.sv
// Purpose : walks 2^TP_NUM Chase test patterns in gray order, updating odd syndromes by one XOR row per step.
// Latency : first out_valid 1 cycle after in_ctr_start, then one pattern per cycle while in_ready is high.
// Backpr. : valid/ready; the presented pattern is held while in_ready is low. Optional TSG_ZERO_DET_EN adds out_zero.
module tsg_gray_param #(
    parameter int GF_LEN   = 10,
    parameter int TP_NUM   = 3,
    parameter int SYND_NUM = 3
) (
    input  logic                              clk,
    input  logic                              in_ctr_Arst_n,
    input  logic                              in_ctr_start,
    input  logic                              in_ctr_abort,
    input  logic [SYND_NUM*GF_LEN-1:0]        in_hd_synd,
    input  logic [TP_NUM*SYND_NUM*GF_LEN-1:0] in_tp_pow,
    output logic                              out_busy,
    output logic                              out_valid,
    input  logic                              in_ready,
    output logic [SYND_NUM*GF_LEN-1:0]        out_test_synd,
    output logic [TP_NUM-1:0]                 out_gray,
    output logic                              out_last
`ifdef TSG_ZERO_DET_EN
    ,
    output logic                              out_zero
`endif
);

    localparam int SW = SYND_NUM * GF_LEN;
    localparam int PW = TP_NUM * SW;
    localparam logic [TP_NUM-1:0] CNT_ONE = TP_NUM'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TP_NUM-1:0] cnt_q, cnt_d;
    logic [SW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     pow_q, pow_d;
    logic              arm_q;

    logic              at_last;
    logic              load_go;
    logic              adv_go;
    logic [TP_NUM-1:0] flip_oh;
    logic [SW-1:0]     flip_xor;

    assign at_last = (cnt_q == {TP_NUM{1'b1}});
    // arm_q keeps the first edge after reset release from accepting a start
    assign load_go = (state_q == IDLE) && in_ctr_start && arm_q && !in_ctr_abort;
    assign adv_go  = out_valid && in_ready && !at_last && !in_ctr_abort;

    // State register; async reset discards any sequence in progress
    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state_q <= IDLE;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= 1'b1;
        end
    end

    // Next-state logic; abort overrides start and transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_go) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (out_valid && in_ready && at_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (in_ctr_abort) state_d = IDLE;
    end

    // Output decode; everything is taken straight from registers
    always_comb begin
        out_busy      = (state_q != IDLE);
        out_valid     = (state_q == LOAD) || (state_q == RUN);
        out_last      = out_valid && at_last;
        out_gray      = cnt_q ^ (cnt_q >> 1);
        out_test_synd = acc_q;
    end

    // Gray bit that flips on n -> n+1 is the lowest zero bit of n; gather its power row
    always_comb begin
        flip_oh  = ~cnt_q & (cnt_q + CNT_ONE);
        flip_xor = '0;
        for (int j = 0; j < TP_NUM; j++) begin
            if (flip_oh[j]) flip_xor = flip_xor ^ pow_q[j*SW +: SW];
        end
    end

    // Datapath next state: capture operands on start, XOR one row per transfer
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        pow_d = pow_q;
        if (load_go) begin
            cnt_d = '0;
            acc_d = in_hd_synd;
            pow_d = in_tp_pow;
        end else if (adv_go) begin
            cnt_d = cnt_q + CNT_ONE;
            acc_d = acc_q ^ flip_xor;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            pow_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            pow_q <= pow_d;
        end
    end

`ifdef TSG_ZERO_DET_EN
    logic zero_q;

    // Zero flag tracks the accumulator it describes, updated on the same edge
    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= (acc_d == '0);
        end
    end

    assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_tsg_gray_param.sv
// Bench for tsg_gray_param at GF_LEN=10, TP_NUM=3, SYND_NUM=3.
// Expected syndromes are summed directly from the set bits of each gray code.
module tb_tsg_gray_param;

    localparam int GF   = 10;
    localparam int TP   = 3;
    localparam int SY   = 3;
    localparam int SW   = SY * GF;
    localparam int PW   = TP * SW;
    localparam int NPAT = 1 << TP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [SW-1:0] hd_synd;
    logic [PW-1:0] tp_pow;
    logic          busy;
    logic          valid;
    logic          ready;
    logic [SW-1:0] test_synd;
    logic [TP-1:0] gray;
    logic          last;
`ifdef TSG_ZERO_DET_EN
    logic          zero;
`endif

    int checks   = 0;
    int failures = 0;

    logic [GF-1:0] hd_m  [SY];
    logic [GF-1:0] pow_m [TP][SY];

    always #5 clk = ~clk;

    tsg_gray_param #(.GF_LEN(GF), .TP_NUM(TP), .SYND_NUM(SY)) dut (
        .clk           (clk),
        .in_ctr_Arst_n (rst_n),
        .in_ctr_start  (start),
        .in_ctr_abort  (abort),
        .in_hd_synd    (hd_synd),
        .in_tp_pow     (tp_pow),
        .out_busy      (busy),
        .out_valid     (valid),
        .in_ready      (ready),
        .out_test_synd (test_synd),
        .out_gray      (gray),
        .out_last      (last)
`ifdef TSG_ZERO_DET_EN
        ,
        .out_zero      (zero)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Test pattern n flips every position whose bit is set in gray(n)
    function automatic logic [SW-1:0] model_synd(input int n);
        logic [SW-1:0] r;
        logic [GF-1:0] s;
        int g;
        g = n ^ (n >> 1);
        r = '0;
        for (int k = 0; k < SY; k++) begin
            s = hd_m[k];
            for (int j = 0; j < TP; j++)
                if (((g >> j) & 1) != 0) s = s ^ pow_m[j][k];
            r[k*GF +: GF] = s;
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] pack_hd();
        logic [SW-1:0] r;
        for (int k = 0; k < SY; k++) r[k*GF +: GF] = hd_m[k];
        return r;
    endfunction

    function automatic logic [PW-1:0] pack_pow();
        logic [PW-1:0] r;
        for (int j = 0; j < TP; j++)
            for (int k = 0; k < SY; k++) r[(j*SY+k)*GF +: GF] = pow_m[j][k];
        return r;
    endfunction

    task automatic set_directed();
        for (int k = 0; k < SY; k++) hd_m[k] = GF'(1 << k);
        for (int j = 0; j < TP; j++)
            for (int k = 0; k < SY; k++) pow_m[j][k] = (k == 0) ? GF'(16 << j) : '0;
    endtask

    task automatic set_random();
        for (int k = 0; k < SY; k++) hd_m[k] = GF'($urandom);
        for (int j = 0; j < TP; j++)
            for (int k = 0; k < SY; k++) pow_m[j][k] = GF'($urandom);
    endtask

    task automatic scramble_inputs();
        hd_synd = SW'($urandom);
        tp_pow  = PW'({$urandom, $urandom, $urandom});
    endtask

    // Pulse start with the model operands, then garble the input buses
    task automatic do_start();
        @(negedge clk);
        hd_synd = pack_hd();
        tp_pow  = pack_pow();
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
    endtask

    // mode 0: ready high; 1: 3-cycle stall on pattern 2; 2: random ready;
    // 3: ready high plus a foreign start pulse on pattern 2.
    // Returns with pattern stop_at presented (stop_at < 0 runs to completion).
    task automatic stream(input int mode, input int stop_at);
        int n;
        int stall;
        int cyc;
        logic r;
        n = 0;
        stall = 0;
        cyc = 0;
        while (n < NPAT && n != stop_at && cyc < 100) begin
            chk("valid", valid, 1);
            chk("busy", busy, 1);
            chk("gray", gray, n ^ (n >> 1));
            chk("synd", test_synd, model_synd(n));
            chk("last", last, n == NPAT - 1);
`ifdef TSG_ZERO_DET_EN
            chk("zero", zero, model_synd(n) == '0);
`endif
            case (mode)
                1: begin
                    if (n == 2 && stall < 3) begin
                        r = 1'b0;
                        stall++;
                    end else r = 1'b1;
                end
                2: r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            ready = r;
            if (mode == 3 && n == 2) start = 1'b1;
            scramble_inputs();
            @(negedge clk);
            start = 1'b0;
            if (r) n++;
            cyc++;
        end
        checks++;
        assert (cyc < 100) else begin
            failures++;
            $error("FAIL budget observed=%0d expected=<100", cyc);
        end
        ready = 1'b1;
        if (stop_at < 0) begin
            chk("end_valid", valid, 0);
            chk("end_busy", busy, 0);
            chk("end_last", last, 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_gray"}, gray, 0);
        chk({tag, "_synd"}, test_synd, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        ready   = 1'b1;
        hd_synd = '0;
        tp_pow  = '0;

        // Reset state
        #12;
        chk_all_zero("rst");
`ifdef TSG_ZERO_DET_EN
        chk("rst_zero", zero, 0);
`endif

        // Start held across the release edge must be ignored
        @(negedge clk);
        set_directed();
        hd_synd = pack_hd();
        tp_pow  = pack_pow();
        rst_n   = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_at_release_busy", busy, 0);
        chk("start_at_release_valid", valid, 0);

        // Directed run, ready always high
        set_directed();
        do_start();
        stream(0, -1);

        // Same run with a 3-cycle stall on pattern 2
        do_start();
        stream(1, -1);

        // Abort on pattern 4 together with a transfer
        do_start();
        stream(0, 4);
        abort = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_last", last, 0);
        do_start();
        stream(0, -1);

        // Start pulse with other operands during RUN is ignored
        set_random();
        do_start();
        stream(3, -1);

        // Asynchronous reset mid-cycle on pattern 5
        set_directed();
        do_start();
        stream(0, 5);
        ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ready = 1'b1;
        chk_all_zero("arst_hold");

        // Random operands with random backpressure
        for (int t = 0; t < 6; t++) begin
            set_random();
            do_start();
            stream(2, -1);
        end

`ifdef TSG_ZERO_DET_EN
        // Zero detect: pattern 1 cancels S1 exactly
        for (int k = 0; k < SY; k++) hd_m[k] = '0;
        for (int j = 0; j < TP; j++)
            for (int k = 0; k < SY; k++) pow_m[j][k] = '0;
        hd_m[0]     = 10'h011;
        pow_m[0][0] = 10'h011;
        do_start();
        chk("zd_p0", zero, 0);
        stream(0, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
